// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the NoC injection path: payload width, type tags,
// FSM state encoding and the head/body/tail tagging helper.
package noc_flit_pkg;

   localparam int unsigned NOC_DATA_W = 20;
   localparam int unsigned NOC_FLIT_W = NOC_DATA_W + 2;

   localparam logic [1:0] FLIT_TYPE_BODY   = 2'b00;
   localparam logic [1:0] FLIT_TYPE_HEAD   = 2'b01;
   localparam logic [1:0] FLIT_TYPE_TAIL   = 2'b10;
   localparam logic [1:0] FLIT_TYPE_SINGLE = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_INJECT = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // A one-flit packet is both first and last, hence SINGLE.
   function automatic logic [1:0] flit_type(input logic is_first, input logic is_last);
      logic [1:0] t;
      if (is_first && is_last) t = FLIT_TYPE_SINGLE;
      else if (is_first)       t = FLIT_TYPE_HEAD;
      else if (is_last)        t = FLIT_TYPE_TAIL;
      else                     t = FLIT_TYPE_BODY;
      return t;
   endfunction

endpackage

// File: rtl/sync_fifo_skid.sv
// Single-clock skid FIFO with registered occupancy; head word is read combinationally.
// A pop on a full FIFO frees the slot for a same-edge write.
module sync_fifo_skid #(
   parameter int unsigned DATA_W     = 20,
   parameter int unsigned FIFO_DEPTH = 8,
   localparam int unsigned AW = $clog2(FIFO_DEPTH),
   localparam int unsigned LW = AW + 1
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [LW-1:0]     level,
   output logic [LW-1:0]     level_nxt
);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              wr_do;
   logic              rd_do;

   assign full    = (level == LW'(FIFO_DEPTH));
   assign empty   = (level == '0);
   assign rd_do   = rd_en && !empty;
   assign wr_do   = wr_en && (!full || rd_do);
   assign rd_data = mem[rd_ptr];

   always_comb begin
      level_nxt = level;
      if (wr_do && !rd_do)      level_nxt = level + LW'(1);
      else if (!wr_do && rd_do) level_nxt = level - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (wr_do) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_do) wr_ptr <= wr_ptr + AW'(1);
         if (rd_do) rd_ptr <= rd_ptr + AW'(1);
         level <= level_nxt;
      end
   end

endmodule

// File: rtl/flit_inject_ni.sv
// NI injection stage: buffers source words, throttles the source, tags flits
// head/body/tail and issues them to the router under credit flow control.
module flit_inject_ni
   import noc_flit_pkg::*;
#(
   parameter int unsigned DATA_W     = NOC_DATA_W,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned PKT_LEN    = 30,
   parameter int unsigned CREDITS    = 4,
   parameter int unsigned SKID       = 3,
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              start,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              src_enable,
   output logic [DATA_W+1:0] flit_out,
   output logic              flit_valid,
   input  logic              credit_in,
   output logic              pkt_done,
   output logic              overflow,
   output logic [LW-1:0]     fifo_level
);

   localparam int unsigned CW = $clog2(CREDITS + 1);
   localparam int unsigned IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [LW-1:0] EN_LIMIT   = LW'(FIFO_DEPTH - SKID);
   localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);
   localparam logic [IW-1:0] IDX_LAST   = IW'(PKT_LEN - 1);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [CW-1:0]     credit_cnt;
   logic [IW-1:0]     flit_idx;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LW-1:0]     level_nxt;
   logic              issue;
   logic              idx_last;

   sync_fifo_skid #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .RST       (RST),
      .wr_en     (din_valid),
      .wr_data   (din),
      .rd_en     (issue),
      .rd_data   (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level),
      .level_nxt (level_nxt)
   );

   assign issue    = (state == ST_INJECT) && !fifo_empty && (credit_cnt != '0);
   assign idx_last = (flit_idx == IDX_LAST);
   assign pkt_done = (state == ST_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_INJECT;
         ST_INJECT: if (issue && idx_last) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state      <= ST_IDLE;
         credit_cnt <= CREDIT_MAX;
         flit_idx   <= '0;
         flit_valid <= 1'b0;
         flit_out   <= '0;
         src_enable <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         // Enable looks at post-edge occupancy so in-flight source words still fit.
         src_enable <= (state_nxt == ST_INJECT) && (level_nxt < EN_LIMIT);
         if (din_valid && fifo_full && !issue) overflow <= 1'b1;

         flit_valid <= issue;
         if (issue) begin
            flit_out <= {flit_type(flit_idx == '0, idx_last), fifo_head};
            flit_idx <= idx_last ? '0 : flit_idx + IW'(1);
         end

         case ({issue, credit_in})
            2'b10:   credit_cnt <= credit_cnt - CW'(1);
            2'b01:   if (credit_cnt != CREDIT_MAX) credit_cnt <= credit_cnt + CW'(1);
            default: credit_cnt <= credit_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_flit_inject_ni.sv
// Scoreboard bench for flit_inject_ni: driver pushes expected flits as words are
// offered, a negedge monitor pops and compares every valid flit.
module tb_flit_inject_ni;

   localparam int PKT_LEN = 30;

   logic        clk = 1'b0;
   logic        RST;
   logic        start;
   logic [19:0] din;
   logic        din_valid;
   logic        src_enable;
   logic [21:0] flit_out;
   logic        flit_valid;
   logic        credit_in;
   logic        pkt_done;
   logic        overflow;
   logic [3:0]  fifo_level;

   always #5 clk = ~clk;

   flit_inject_ni #(
      .DATA_W     (20),
      .FIFO_DEPTH (8),
      .PKT_LEN    (PKT_LEN),
      .CREDITS    (4),
      .SKID       (3)
   ) dut (
      .clk        (clk),
      .RST        (RST),
      .start      (start),
      .din        (din),
      .din_valid  (din_valid),
      .src_enable (src_enable),
      .flit_out   (flit_out),
      .flit_valid (flit_valid),
      .credit_in  (credit_in),
      .pkt_done   (pkt_done),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   int          checks = 0;
   int          errors = 0;
   logic [21:0] exp_q[$];
   logic [21:0] mon_exp;
   int          exp_idx = 0;
   int          n_flits = 0;
   int          n_done = 0;
   int          max_level = 0;

   bit          src_on = 0;
   int          src_cnt = 0;
   int          src_lim = 0;
   bit          frc_on = 0;
   logic [19:0] frc_data = '0;
   bit          auto_credit = 0;
   bit          man_credit = 0;
   bit          start_req = 0;
   logic [1:0]  cpipe = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic [1:0] exp_type(input int idx);
      if (idx == 0) return 2'b01;
      if (idx == PKT_LEN - 1) return 2'b10;
      return 2'b00;
   endfunction

   task automatic push_exp(input logic [19:0] w);
      exp_q.push_back({exp_type(exp_idx), w});
      exp_idx = (exp_idx == PKT_LEN - 1) ? 0 : exp_idx + 1;
   endtask

   // All inputs are driven here, at the falling edge, for the next rising edge.
   task automatic tick();
      @(negedge clk);
      start     = start_req;
      credit_in = man_credit || (auto_credit && cpipe[1]);
      cpipe     = {cpipe[0], flit_valid};
      if (frc_on) begin
         din_valid = 1'b1;
         din       = frc_data;
      end else if (src_on && src_enable && src_cnt < src_lim) begin
         din_valid = 1'b1;
         din       = 20'(src_cnt);
         push_exp(din);
         src_cnt++;
      end else begin
         din_valid = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset(input string tag);
      RST = 1'b0;
      src_on = 0; frc_on = 0; auto_credit = 0; man_credit = 0; start_req = 0;
      cpipe = '0; exp_q.delete(); exp_idx = 0; src_cnt = 0; n_flits = 0; n_done = 0;
      #1;
      check({tag, "_src_enable"}, 32'(src_enable), 0);
      check({tag, "_flit_valid"}, 32'(flit_valid), 0);
      check({tag, "_flit_out"},   32'(flit_out),   0);
      check({tag, "_pkt_done"},   32'(pkt_done),   0);
      check({tag, "_overflow"},   32'(overflow),   0);
      check({tag, "_fifo_level"}, 32'(fifo_level), 0);
      repeat (2) tick();
      RST = 1'b1;
   endtask

   task automatic pulse_start();
      start_req = 1;
      tick();
      start_req = 0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (n_done == 0 && k < budget) begin
         tick();
         k++;
      end
   endtask

   always @(negedge clk) begin
      if (RST === 1'b1) begin
         if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
         if (flit_valid === 1'b1) begin
            n_flits++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL flit_unexpected actual=0x%06h required=none", flit_out);
            end else begin
               mon_exp = exp_q.pop_front();
               check("flit", 32'(flit_out), 32'(mon_exp));
            end
         end
         if (pkt_done === 1'b1) begin
            n_done++;
            check("done_with_tail", {29'd0, flit_valid, flit_out[21:20]}, 32'b110);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b0; start = 1'b0; din = '0; din_valid = 1'b0; credit_in = 1'b0;

      // Basic packet: 30 words, credit back 2 cycles after each flit.
      do_reset("rst0");
      auto_credit = 1; src_on = 1; src_lim = 30;
      pulse_start();
      repeat (15) tick();
      pulse_start();
      wait_done(400);
      repeat (5) tick();
      check("basic_flits",    32'(n_flits),      30);
      check("basic_done",     32'(n_done),       1);
      check("basic_overflow", 32'(overflow),     0);
      check("basic_q_empty",  32'(exp_q.size()), 0);
      check("basic_src_off",  32'(src_enable),   0);

      // Credit saturation in IDLE, then starvation with no returns.
      do_reset("rst1");
      src_on = 1; src_lim = 1000;
      man_credit = 1;
      repeat (3) tick();
      man_credit = 0;
      pulse_start();
      repeat (9) tick();
      pulse_start();
      repeat (10) tick();
      check("starve_flits",  32'(n_flits),    4);
      check("starve_level",  32'(fifo_level), 5);
      check("starve_src_en", 32'(src_enable), 0);
      man_credit = 1;
      tick();
      man_credit = 0;
      repeat (6) tick();
      check("one_credit_flits", 32'(n_flits),    5);
      check("one_credit_level", 32'(fifo_level), 5);
      man_credit = 1;
      repeat (2) tick();
      man_credit = 0;
      repeat (6) tick();
      check("credit_and_issue_flits", 32'(n_flits), 7);

      // Overflow: 10 forced words into an idle NI with depth 8.
      do_reset("rst2");
      frc_on = 1;
      for (int i = 0; i < 10; i++) begin
         frc_data = 20'h00100 + 20'(i);
         if (i < 8) push_exp(frc_data);
         tick();
         @(posedge clk);
         #1;
         check("ovf_flag",  32'(overflow),   (i >= 8) ? 1 : 0);
         check("ovf_level", 32'(fifo_level), (i < 8) ? i + 1 : 8);
      end
      frc_on = 0;
      repeat (5) tick();
      check("ovf_sticky", 32'(overflow), 1);
      auto_credit = 1;
      pulse_start();
      repeat (40) tick();
      check("ovf_buffered_flits", 32'(n_flits),  8);
      check("ovf_still_sticky",   32'(overflow), 1);

      // Reset mid-packet, then a fresh packet must start with a head flit.
      do_reset("rst3");
      auto_credit = 1; src_on = 1; src_lim = 1000;
      pulse_start();
      begin
         int k;
         k = 0;
         while (n_flits < 12 && k < 200) begin
            tick();
            k++;
         end
      end
      check("mid_reached_12", 32'(n_flits), 12);
      do_reset("rst_mid");
      auto_credit = 1; src_on = 1; src_lim = 30;
      pulse_start();
      wait_done(400);
      repeat (5) tick();
      check("after_rst_flits", 32'(n_flits), 30);
      check("after_rst_done",  32'(n_done),  1);

      check("max_level", 32'(max_level), 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
